// File: rtl/simd_pkg.sv
// ---------------------------------------------------------------------------
// simd_pkg : shared defaults, saturation-mode enum and popcount helper. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package simd_pkg;

  localparam int DEF_NLANE = 4;
  localparam int DEF_WIN   = 16;
  localparam int DEF_WOUT  = 8;

  typedef enum logic {
    SAT_SIGNED   = 1'b0,
    SAT_UNSIGNED = 1'b1
  } sat_mode_e;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/simd_requant_sat_if.sv
// ---------------------------------------------------------------------------
// simd_requant_sat_if : input/output valid-ready beat bus of the requant stage. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface simd_requant_sat_if
  import simd_pkg::*;
#(
  parameter int NLANE = DEF_NLANE,
  parameter int WIN   = DEF_WIN,
  parameter int WOUT  = DEF_WOUT,
  parameter int SHW   = $clog2(WIN)
);

  logic                  in_valid;
  logic                  in_ready;
  logic [NLANE*WIN-1:0]  in_data;
  logic [SHW-1:0]        in_shift;
  logic                  in_unsigned;
  logic                  out_valid;
  logic                  out_ready;
  logic [NLANE*WOUT-1:0] out_data;
  logic [NLANE-1:0]      out_sat;

  modport slave (
    input  in_valid, in_data, in_shift, in_unsigned, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

  modport master (
    output in_valid, in_data, in_shift, in_unsigned, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

endinterface

`default_nettype wire

// File: rtl/simd_requant_sat_lane.sv
// ---------------------------------------------------------------------------
// requant_lane : combinational round-half-up right shift then signed/unsigned clamp. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module requant_lane
  import simd_pkg::*;
#(
  parameter int WIN  = DEF_WIN,
  parameter int WOUT = DEF_WOUT,
  parameter int SHW  = $clog2(WIN)
) (
  input  logic [WIN-1:0]  x,
  input  logic [SHW-1:0]  shift,
  input  sat_mode_e       unsigned_mode,
  output logic [WOUT-1:0] y,
  output logic            sat
);

  localparam logic signed [WIN:0] c_smax = (WIN+1)'((1 << (WOUT-1)) - 1);
  localparam logic signed [WIN:0] c_smin = (WIN+1)'(-(1 << (WOUT-1)));
  localparam logic signed [WIN:0] c_umax = (WIN+1)'((1 << WOUT) - 1);

  logic signed [WIN:0] w_xe;
  logic signed [WIN:0] w_rnd;
  logic signed [WIN:0] w_v;

  // One guard bit keeps x + 2^(shift-1) from overflowing for any legal shift.
  always_comb begin
    w_xe  = {x[WIN-1], x};
    w_rnd = '0;
    w_v   = w_xe;
    if (shift != '0) begin
      w_rnd = (WIN+1)'(1) << (shift - SHW'(1));
      w_v   = (w_xe + w_rnd) >>> shift;
    end
  end

  always_comb begin
    y   = w_v[WOUT-1:0];
    sat = 1'b0;
    if (unsigned_mode == SAT_UNSIGNED) begin
      if (w_v[WIN]) begin
        y   = '0;
        sat = 1'b1;
      end else if (w_v > c_umax) begin
        y   = '1;
        sat = 1'b1;
      end
    end else begin
      if (w_v > c_smax) begin
        y   = {1'b0, {(WOUT-1){1'b1}}};
        sat = 1'b1;
      end else if (w_v < c_smin) begin
        y   = {1'b1, {(WOUT-1){1'b0}}};
        sat = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/simd_requant_sat.sv
// ---------------------------------------------------------------------------
// simd_requant_sat : NLANE-lane requantiser, 2-stage pipe with backpressure and sticky sat counter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module simd_requant_sat
  import simd_pkg::*;
#(
  parameter int NLANE = DEF_NLANE,
  parameter int WIN   = DEF_WIN,
  parameter int WOUT  = DEF_WOUT,
  parameter int SHW   = $clog2(WIN),
  parameter int CNTW  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  simd_requant_sat_if.slave   bus,
  input  logic                sat_clr,
  output logic [CNTW-1:0]     sat_count
);

  logic                  s1_valid_q;
  logic [NLANE*WIN-1:0]  s1_data_q;
  logic [SHW-1:0]        s1_shift_q;
  sat_mode_e             s1_mode_q;
  logic                  out_valid_q;
  logic [NLANE*WOUT-1:0] out_data_q;
  logic [NLANE-1:0]      out_sat_q;
  logic [CNTW-1:0]       sat_count_q;
  logic [CNTW-1:0]       sat_count_d;

  logic                  w_adv;
  logic                  w_hs;
  logic [NLANE*WOUT-1:0] w_y;
  logic [NLANE-1:0]      w_sat;
  logic [CNTW-1:0]       w_pop;
  logic [CNTW:0]         w_sum;

  assign w_adv        = !out_valid_q || bus.out_ready;
  assign w_hs         = out_valid_q && bus.out_ready;
  assign bus.in_ready = w_adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign sat_count     = sat_count_q;

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    requant_lane #(
      .WIN  (WIN),
      .WOUT (WOUT),
      .SHW  (SHW)
    ) u_lane (
      .x             (s1_data_q[i*WIN +: WIN]),
      .shift         (s1_shift_q),
      .unsigned_mode (s1_mode_q),
      .y             (w_y[i*WOUT +: WOUT]),
      .sat           (w_sat[i])
    );
  end

  // Both stages move together; a stalled output freezes the whole pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_shift_q  <= '0;
      s1_mode_q   <= SAT_SIGNED;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
    end else if (w_adv) begin
      s1_valid_q  <= bus.in_valid;
      out_valid_q <= s1_valid_q;
      if (bus.in_valid) begin
        s1_data_q  <= bus.in_data;
        s1_shift_q <= bus.in_shift;
        s1_mode_q  <= sat_mode_e'(bus.in_unsigned);
      end
      if (s1_valid_q) begin
        out_data_q <= w_y;
        out_sat_q  <= w_sat;
      end
    end
  end

  always_comb begin
    w_pop       = CNTW'(popcount(32'(out_sat_q)));
    w_sum       = {1'b0, sat_count_q} + {1'b0, w_pop};
    sat_count_d = sat_count_q;
    if (w_hs) begin
      if (sat_clr) begin
        sat_count_d = w_pop;
      end else if (w_sum[CNTW]) begin
        sat_count_d = '1;
      end else begin
        sat_count_d = w_sum[CNTW-1:0];
      end
    end else if (sat_clr) begin
      sat_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_simd_requant_sat.sv
// ---------------------------------------------------------------------------
// tb_simd_requant_sat : directed vectors into a scoreboard, two builds (CNTW=32 and CNTW=4). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_simd_requant_sat;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_a = 1'b0;
  logic        clr_b = 1'b0;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  simd_requant_sat_if #(.NLANE(4), .WIN(16), .WOUT(8)) bus_a ();
  simd_requant_sat_if #(.NLANE(4), .WIN(16), .WOUT(8)) bus_b ();

  simd_requant_sat #(.NLANE(4), .WIN(16), .WOUT(8), .CNTW(32)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .sat_clr(clr_a), .sat_count(cnt_a)
  );

  simd_requant_sat #(.NLANE(4), .WIN(16), .WOUT(8), .CNTW(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .sat_clr(clr_b), .sat_count(cnt_b)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
  } exp_t;

  exp_t   qa[$];
  exp_t   qb[$];
  int     n_cmp = 0;
  int     n_fail = 0;
  longint mdl_a = 0;
  longint mdl_b = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic longint upd(input longint c, input logic [3:0] s, input logic clr,
                                 input longint mx);
    longint t;
    t = longint'($countones(s));
    if (clr) return t;
    t = c + t;
    return (t > mx) ? mx : t;
  endfunction

  // Monitor for the CNTW=32 build: data/sat order, stall behaviour, counter model.
  logic        stall_a = 1'b0;
  logic [31:0] held_a;
  exp_t        ea;
  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      mdl_a   = 0;
      stall_a = 1'b0;
    end else begin
      check("sat_count_a", 64'(cnt_a), 64'(mdl_a));
      if (stall_a) check("hold_data", 64'(bus_a.out_data), 64'(held_a));
      if (bus_a.out_valid && !bus_a.out_ready)
        check("in_ready_stall", 64'(bus_a.in_ready), 64'd0);
      if (bus_a.out_valid && bus_a.out_ready) begin
        if (qa.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat_a: got %h expected none", bus_a.out_data);
        end else begin
          ea = qa.pop_front();
          check("out_data_a", 64'(bus_a.out_data), 64'(ea.d));
          check("out_sat_a", 64'(bus_a.out_sat), 64'(ea.s));
          mdl_a = upd(mdl_a, ea.s, clr_a, 64'hFFFF_FFFF);
        end
      end else if (clr_a) begin
        mdl_a = 0;
      end
      stall_a = bus_a.out_valid && !bus_a.out_ready;
      held_a  = bus_a.out_data;
    end
  end

  exp_t eb;
  always @(negedge clk) begin
    if (!rst_n) begin
      qb.delete();
      mdl_b = 0;
    end else begin
      check("sat_count_b", 64'(cnt_b), 64'(mdl_b));
      if (bus_b.out_valid && bus_b.out_ready) begin
        if (qb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat_b: got %h expected none", bus_b.out_data);
        end else begin
          eb = qb.pop_front();
          check("out_data_b", 64'(bus_b.out_data), 64'(eb.d));
          check("out_sat_b", 64'(bus_b.out_sat), 64'(eb.s));
          mdl_b = upd(mdl_b, eb.s, clr_b, 64'd15);
        end
      end else if (clr_b) begin
        mdl_b = 0;
      end
    end
  end

  task automatic send(input bit b, input logic [63:0] d, input logic [3:0] sh, input logic u,
                      input logic [31:0] ed, input logic [3:0] es);
    int   n;
    logic rdy;
    n = 0;
    if (b) begin
      bus_b.in_valid = 1'b1; bus_b.in_data = d; bus_b.in_shift = sh; bus_b.in_unsigned = u;
    end else begin
      bus_a.in_valid = 1'b1; bus_a.in_data = d; bus_a.in_shift = sh; bus_a.in_unsigned = u;
    end
    @(negedge clk);
    rdy = b ? bus_b.in_ready : bus_a.in_ready;
    while (!rdy && n < 200) begin
      @(negedge clk);
      n++;
      rdy = b ? bus_b.in_ready : bus_a.in_ready;
    end
    if (!rdy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end else if (b) begin
      qb.push_back(exp_t'({ed, es}));
    end else begin
      qa.push_back(exp_t'({ed, es}));
    end
    @(posedge clk);
    #1;
    if (b) bus_b.in_valid = 1'b0;
    else   bus_a.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(qa.size() + qb.size()), 64'd0);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] sd;
    logic [31:0] se;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_shift = '0; bus_a.in_unsigned = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_shift = '0; bus_b.in_unsigned = 1'b0;
    bus_a.out_ready = 1'b0;
    bus_b.out_ready = 1'b1;

    #2;
    check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
    check("rst_out_data", 64'(bus_a.out_data), 64'd0);
    check("rst_out_sat", 64'(bus_a.out_sat), 64'd0);
    check("rst_sat_count", 64'(cnt_a), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_a.out_ready = 1'b1;

    // Signed, shift 0, {100,-100,200,-200}; also checks the two-cycle latency.
    send(0, 64'hFF38_00C8_FF9C_0064, 4'd0, 1'b0, 32'h807F_9C64, 4'b1100);
    @(negedge clk);
    check("lat_stage1", 64'(bus_a.out_valid), 64'd0);
    @(negedge clk);
    check("lat_stage2", 64'(bus_a.out_valid), 64'd1);
    wait_drain();

    send(0, 64'h7FFF_0017_FFE8_0018, 4'd4, 1'b0, 32'h7F01_FF02, 4'b1000);
    send(0, 64'h00FF_00C8_012C_FFFB, 4'd0, 1'b1, 32'hFFC8_FF00, 4'b0011);
    send(0, 64'hFFFC_FFFF_FFFD_0003, 4'd1, 1'b0, 32'hFE00_FF02, 4'b0000);
    send(0, 64'hFF7F_0080_FF80_007F, 4'd0, 1'b0, 32'h807F_807F, 4'b1100);
    send(0, 64'hFFFF_0100_00FF_0000, 4'd0, 1'b1, 32'h00FF_FF00, 4'b1100);
    send(0, 64'hC000_7FFF_4000_8000, 4'd15, 1'b0, 32'h0001_01FF, 4'b0000);
    wait_drain();

    // Eight back-to-back beats with the output stalled for five cycles.
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          for (int j = 0; j < 4; j++) begin
            sd[j*16 +: 16] = 16'(16*k + j + 1);
            se[j*8 +: 8]   = 8'(16*k + j + 1);
          end
          send(0, sd, 4'd0, 1'b0, se, 4'b0000);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus_a.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus_a.out_ready = 1'b1;
      end
    join
    wait_drain();

    clr_a = 1'b1;
    @(posedge clk);
    #1 clr_a = 1'b0;
    check("sat_clr_alone", 64'(cnt_a), 64'd0);

    // 4-bit counter build: 6 fully clamped beats stick at 15.
    for (int k = 0; k < 6; k++)
      send(1, 64'hFF38_FF38_00C8_00C8, 4'd0, 1'b0, 32'h8080_7F7F, 4'b1111);
    wait_drain();
    check("cnt_clamp", 64'(cnt_b), 64'd15);

    send(1, 64'hFF38_00C8_FF9C_0064, 4'd0, 1'b0, 32'h807F_9C64, 4'b1100);
    @(posedge clk);
    #1 clr_b = 1'b1;
    @(posedge clk);
    #1 clr_b = 1'b0;
    check("clr_with_beat", 64'(cnt_b), 64'd2);
    wait_drain();

    // Asynchronous reset with two beats in flight.
    send(0, 64'hFF38_00C8_FF9C_0064, 4'd0, 1'b0, 32'h807F_9C64, 4'b1100);
    wait_drain();
    check("pre_reset_count", 64'(cnt_a), 64'd2);
    send(0, 64'h7FFF_0017_FFE8_0018, 4'd4, 1'b0, 32'h7F01_FF02, 4'b1000);
    send(0, 64'h00FF_00C8_012C_FFFB, 4'd0, 1'b1, 32'hFFC8_FF00, 4'b0011);
    check("inflight_valid", 64'(bus_a.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus_a.out_valid), 64'd0);
    check("async_rst_count", 64'(cnt_a), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("no_stale_beat", 64'(bus_a.out_valid), 64'd0);
    check("post_rst_count", 64'(cnt_a), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/simd_requant_sat.md
Name: simd_requant_sat

Overview:
Multi-lane, pipelined requantisation stage for the SIMD datapath. Takes N signed accumulator-width lanes and applies a per-beat runtime rounding right-shift. Each lane is then saturated to an output width, either signed or unsigned, selected per beat. Sits between the SIMD ALU/accumulator and the output writeback path, uses a valid/ready handshake with full backpressure, and reports per-lane saturation events plus a sticky saturating event counter.

Parameters:
NLANE, 4, number of parallel lanes
WIN, 16, input lane width (signed two's complement), must be > WOUT
WOUT, 8, output lane width
SHW, $clog2(WIN), width of shift-amount field
CNTW, 32, width of saturation event counter

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
in_data  input  NLANE*WIN  packed lanes, lane 0 in LSBs
in_shift  input  SHW  right-shift amount for this beat, 0..WIN-1
in_unsigned  input  1  1 = saturate to unsigned range, 0 = signed
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts beat
out_data  output  NLANE*WOUT  packed saturated lanes, lane 0 in LSBs
out_sat  output  NLANE  per-lane flag, 1 = lane was clamped
sat_clr  input  1  synchronous clear of sat_count
sat_count  output  CNTW  total clamped lanes over accepted output beats, saturating

Behaviour:
- Reset (rst_n low, async): all pipeline valids 0, out_valid 0, out_data 0, out_sat 0, sat_count 0. in_ready is combinational and equals 1 once both stages are empty. Reset mid-stream discards all in-flight beats.
- Two-stage pipeline, latency 2 cycles from input handshake to out_valid with out_ready held high. Throughput is 1 beat per cycle.
- Stall: adv = !out_valid || out_ready. in_ready = adv, combinational, with no dependency on in_valid. When adv = 0, both stages hold. out_data and out_sat stay stable while out_valid && !out_ready.
- Stage 1 (rounding shift), per lane, in WIN+1 bits sign-extended:
  - shift = 0: pass through unchanged.
  - shift > 0: (x + 2^(shift-1)) >>> shift, arithmetic shift, round-half-up toward +inf.
  - in_shift and in_unsigned are registered alongside the data.
- Stage 2 (saturate), per lane, from the WIN+1-bit value v:
  - Signed mode: v > 2^(WOUT-1)-1 gives 0 followed by all ones; v < -2^(WOUT-1) gives 1 followed by all zeros; otherwise v[WOUT-1:0].
  - Unsigned mode: v < 0 gives 0; v > 2^WOUT-1 gives all ones; otherwise v[WOUT-1:0].
  - out_sat[i] = 1 exactly when clamping occurred.
- Counter update: on each output handshake (out_valid && out_ready), sat_count += popcount(out_sat), clamped at 2^CNTW-1 with no wrap.
- sat_clr:
  - Alone: sat_count = 0 next cycle.
  - Same cycle as a handshake: sat_count = popcount(out_sat) of that beat.
- in_shift >= WIN is illegal and not checked.

Decomposition:
- Package simd_pkg holds:
  - default NLANE/WIN/WOUT.
  - A mode enum: SAT_SIGNED = 0, SAT_UNSIGNED = 1.
  - A popcount function used for the counter.
- One natural sub-module, requant_lane: the per-lane round-shift and saturate datapath. It is purely combinational with ports x, shift, unsigned_mode, y, sat. It is instantiated NLANE times, with pipeline registers held in the top.

Test Plan:
- Signed, shift 0, lanes {100, -100, 200, -200} -> after 2 cycles out_data lanes {0x64, 0x9C, 0x7F, 0x80}, out_sat = 4'b1100, sat_count = 2.
- Signed, shift 4, lanes {24, -24, 23, 0x7FFF} -> lanes {2, -1 (0xFF), 1, 0x7F}, out_sat = 4'b1000.
- Unsigned, shift 0, lanes {-5, 300, 200, 255} -> lanes {0x00, 0xFF, 0xC8, 0xFF}, out_sat = 4'b0011.
- Streaming 8 beats with out_ready low for cycles 3-7 -> in_ready low while stalled, out_data held constant, all 8 beats delivered in order with none duplicated.
- Counter checks:
  - Preload via CNTW=4 build, then saturate 6 beats x 4 lanes -> sat_count sticks at 15.
  - sat_clr coincident with a beat of 2 clamped lanes -> sat_count = 2.
- Assert rst_n low with 2 beats in flight -> out_valid 0 immediately (async), no stale beat after release, sat_count = 0.
